// File: rtl/scorer_pkg.sv
// Shared types and helpers for the frame-synchronous penalty scorer.
package scorer_pkg;

  localparam int unsigned SCORE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } scorer_state_t;

  // Saturating increment; callers guarantee lim fits in SCORE_W bits.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    if (v >= lim) return lim;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/scorer_if.sv
// Game-logic side of the scorer: event pulses in, overlay-facing score/status out.
interface scorer_if;

  logic                          new_frame_in;
  logic                          start_in;
  logic                          miss_in;
  logic [scorer_pkg::SCORE_W-1:0] score_out;
  logic                          active_out;
  logic                          game_over_out;

  modport master (
    output new_frame_in, start_in, miss_in,
    input  score_out, active_out, game_over_out
  );

  modport slave (
    input  new_frame_in, start_in, miss_in,
    output score_out, active_out, game_over_out
  );

endinterface

// File: rtl/scorer_frame_timer.sv
// Loadable down-counter that steps once per enabled frame and stops at zero.
module frame_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/scorer.sv
// Penalty scorer: latches in-frame misses and applies them only at frame
// boundaries, with a post-miss cooldown and a round timeout.
module scorer
  import scorer_pkg::*;
#(
  parameter int unsigned MAX_SCORE       = 7,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned ROUND_FRAMES    = 1800
) (
  input  logic     clk_in,
  input  logic     rst_in,
  scorer_if.slave  bus
);

  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int unsigned RF_W = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [RF_W-1:0]    RF_LOAD = RF_W'(ROUND_FRAMES - 1);
  localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);

  scorer_state_t      state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pending_q, pending_d;
  logic               active_q, active_d;
  logic               over_q, over_d;

  logic               eff_miss;
  logic               cd_load, cd_en, cd_zero;
  logic [CD_W-1:0]    cd_val;
  logic               rt_load, rt_en, rt_zero;

  frame_timer #(.W(CD_W)) u_cooldown (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (cd_load),
    .load_val_i (cd_val),
    .en_i       (cd_en),
    .zero_o     (cd_zero)
  );

  // Loaded with ROUND_FRAMES-1, so zero at a frame pulse marks the final frame.
  frame_timer #(.W(RF_W)) u_round (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (rt_load),
    .load_val_i (RF_LOAD),
    .en_i       (rt_en),
    .zero_o     (rt_zero)
  );

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    pending_d = pending_q;
    eff_miss  = 1'b0;
    cd_load   = 1'b0;
    cd_val    = '0;
    cd_en     = 1'b0;
    rt_load   = 1'b0;
    rt_en     = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (bus.start_in) begin
          state_d   = PLAY;
          score_d   = '0;
          pending_d = 1'b0;
          cd_load   = 1'b1;
          rt_load   = 1'b1;
        end
      end
      PLAY: begin
        eff_miss = pending_q | (bus.miss_in & cd_zero);
        if (bus.new_frame_in) begin
          pending_d = 1'b0;
          rt_en     = 1'b1;
          if (eff_miss) begin
            score_d = sat_inc(score_q, MAX_S);
            cd_load = 1'b1;
            cd_val  = CD_LOAD;
          end else begin
            cd_en = 1'b1;
          end
          if ((score_d == MAX_S) || rt_zero) begin
            state_d = OVER;
          end
        end else if (bus.miss_in && cd_zero && !pending_q) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d == PLAY);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      score_q   <= '0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      over_q    <= over_d;
    end
  end

  assign bus.score_out     = score_q;
  assign bus.active_out    = active_q;
  assign bus.game_over_out = over_q;

endmodule

// File: tb/tb_scorer.sv
// Bench for scorer: two instances (short and long round) checked every cycle
// against a rule-level model, plus hand-computed checkpoints.
module tb_scorer;

  logic clk;
  logic rst;
  logic frame, start, miss;

  scorer_if ifa ();
  scorer_if ifb ();

  assign ifa.new_frame_in = frame;
  assign ifa.start_in     = start;
  assign ifa.miss_in      = miss;
  assign ifb.new_frame_in = frame;
  assign ifb.start_in     = start;
  assign ifb.miss_in      = miss;

  scorer #(.MAX_SCORE(7), .COOLDOWN_FRAMES(2), .ROUND_FRAMES(10)) dut_a (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifa)
  );

  scorer #(.MAX_SCORE(7), .COOLDOWN_FRAMES(2), .ROUND_FRAMES(100)) dut_b (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Rule-level model: counts frames upward and tracks cooldown as a plain integer.
  typedef struct {
    bit playing;
    bit over;
    int score;
    bit pending;
    int cool;
    int frames;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit r, input bit s, input bit f,
                                input bit x, input int maxs, input int cd, input int rf);
    mdl_t n;
    bit   eff;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0, 0};
    end else if (!m.playing) begin
      if (s) n = '{1, 0, 0, 0, 0, 0};
    end else begin
      eff = m.pending || (x && m.cool == 0);
      if (f) begin
        if (eff) begin
          n.score = (m.score + 1 > maxs) ? maxs : m.score + 1;
          n.cool  = cd;
        end else if (m.cool > 0) begin
          n.cool = m.cool - 1;
        end
        n.pending = 0;
        n.frames  = m.frames + 1;
        if (n.score == maxs || n.frames == rf) begin
          n.playing = 0;
          n.over    = 1;
        end
      end else if (x && m.cool == 0 && !m.pending) begin
        n.pending = 1;
      end
    end
    return n;
  endfunction

  mdl_t ma = '{0, 0, 0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0, 0, 0};
  bit   started = 0;

  always @(posedge clk) begin
    if (rst) started = 1;
    ma = step(ma, rst, start, frame, miss, 7, 2, 10);
    mb = step(mb, rst, start, frame, miss, 7, 2, 100);
  end

  always @(negedge clk) begin
    if (started) begin
      check("A.score", int'(ifa.score_out), ma.score);
      check("A.active", int'(ifa.active_out), int'(ma.playing));
      check("A.game_over", int'(ifa.game_over_out), int'(ma.over));
      check("B.score", int'(ifb.score_out), mb.score);
      check("B.active", int'(ifb.active_out), int'(mb.playing));
      check("B.game_over", int'(ifb.game_over_out), int'(mb.over));
    end
  end

  task automatic drive(input bit f, input bit s, input bit m);
    @(negedge clk);
    frame = f;
    start = s;
    miss  = m;
    @(posedge clk);
    #1;
    frame = 1'b0;
    start = 1'b0;
    miss  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_a(input string tag, input int sc, input int act, input int ov);
    check({tag, ".A.score"}, int'(ifa.score_out), sc);
    check({tag, ".A.active"}, int'(ifa.active_out), act);
    check({tag, ".A.game_over"}, int'(ifa.game_over_out), ov);
  endtask

  task automatic expect_b(input string tag, input int sc, input int act, input int ov);
    check({tag, ".B.score"}, int'(ifb.score_out), sc);
    check({tag, ".B.active"}, int'(ifb.active_out), act);
    check({tag, ".B.game_over"}, int'(ifb.game_over_out), ov);
  endtask

  initial begin
    rst   = 1'b1;
    frame = 1'b0;
    start = 1'b0;
    miss  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_a("reset", 0, 0, 0);
    expect_b("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: pulses without start have no effect
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      idle(5);
      drive(1'b1, 1'b0, 1'b0);
      idle(5);
      drive(1'b1, 1'b0, 1'b1);
    end
    expect_a("idle", 0, 0, 0);

    // Start, two misses inside one frame, score moves only at the boundary (f1)
    drive(1'b0, 1'b1, 1'b0);
    expect_a("start", 0, 1, 0);
    idle(5);
    drive(1'b0, 1'b0, 1'b1);
    idle(3);
    drive(1'b0, 1'b0, 1'b1);
    idle(9);
    expect_a("preframe", 0, 1, 0);
    drive(1'b1, 1'b0, 1'b0);
    expect_a("f1", 1, 1, 0);

    // Misses during the two cooldown frames are dropped (f2, f3)
    for (int k = 0; k < 2; k++) begin
      idle(9);
      drive(1'b0, 1'b0, 1'b1);
      idle(9);
      drive(1'b1, 1'b0, 1'b0);
      expect_a("cool", 1, 1, 0);
    end
    idle(9);
    drive(1'b0, 1'b0, 1'b1);
    idle(9);
    drive(1'b1, 1'b0, 1'b0);
    expect_a("f4", 2, 1, 0);

    // Coincident miss and frame pulse with cooldown expired (f5, f6, f7)
    for (int k = 0; k < 2; k++) begin
      idle(19);
      drive(1'b1, 1'b0, 1'b0);
    end
    idle(19);
    drive(1'b1, 1'b1 ^ 1'b1, 1'b1);
    expect_a("coinc", 3, 1, 0);

    // Short-round instance times out on its 10th frame (f8..f10)
    for (int k = 0; k < 2; k++) begin
      idle(19);
      drive(1'b1, 1'b0, 1'b0);
    end
    expect_a("f9", 3, 1, 0);
    idle(19);
    drive(1'b1, 1'b0, 1'b0);
    expect_a("timeout1", 3, 0, 1);
    expect_b("f10", 3, 1, 0);

    // Long-round instance saturates at 7 (f11..f22)
    for (int i = 0; i < 12; i++) begin
      idle(19);
      drive(1'b1, 1'b0, 1'b1);
      if (i == 9) expect_b("sat", 7, 0, 1);
    end
    expect_b("postsat", 7, 0, 1);
    expect_a("overhold", 3, 0, 1);

    // Fresh round, ten quiet frames time out with score 0
    drive(1'b0, 1'b1, 1'b0);
    expect_a("restart", 0, 1, 0);
    expect_b("restart", 0, 1, 0);
    for (int j = 0; j < 10; j++) begin
      idle(19);
      drive(1'b1, 1'b0, 1'b0);
      if (j == 8) expect_a("t9", 0, 1, 0);
    end
    expect_a("timeout2", 0, 0, 1);
    drive(1'b0, 1'b1, 1'b0);
    expect_a("restart2", 0, 1, 0);

    // Mid-round reset discards a pending miss
    idle(7);
    drive(1'b0, 1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_a("midrst", 0, 0, 0);
    expect_b("midrst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    expect_a("postrst", 0, 1, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
